// File: rtl/luhn_card_checker_if.sv
// Board-facing switch, button, seven-segment and LED signals of the Luhn card checker.
// The bench drives SW/KEY through master; the checker owns the displays through slave.
interface luhn_card_checker_if;
  logic [9:0] SW;
  logic [1:0] KEY;
  logic [6:0] HEX0;
  logic [6:0] HEX4;
  logic [6:0] HEX5;
  logic [9:0] LEDR;

  modport master (output SW, KEY, input HEX0, HEX4, HEX5, LEDR);
  modport slave  (input SW, KEY, output HEX0, HEX4, HEX5, LEDR);
endinterface

// File: rtl/luhn_card_checker.sv
// Card-number entry from switches/buttons with a Luhn mod-10 check, one digit per cycle.
// The first digit entered is the most significant, so the check walks the buffer from the top index down.
module luhn_card_checker #(
  parameter int MAX_DIGITS = 16
) (
  input logic                  CLOCK_50,
  input logic                  reset,
  luhn_card_checker_if.slave   bus
);
  localparam int CW = 5;
  localparam int IW = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     key_meta_q, key_sync_q, key_prev_q;
  logic [3:0]     buf_q [MAX_DIGITS];
  logic [3:0]     buf_d [MAX_DIGITS];
  logic [CW-1:0]  count_q, count_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           pos_odd_q, pos_odd_d;
  logic [7:0]     sum_q, sum_d;
  logic [3:0]     card_digit_q, card_digit_d;
  logic           valid_q, valid_d;
  logic           pending_q, pending_d;

  logic           enter_press, start_press, digit_ok, has_room, begin_check;
  logic [3:0]     sw_digit, cur_digit, term;
  logic [4:0]     dbl;
  logic [CW-1:0]  last_idx, count_units;
  logic           unused_sw;

  assign unused_sw   = ^bus.SW[9:4];
  assign sw_digit    = bus.SW[3:0];
  // Buttons are active-low: a press is the synchronized 1->0 transition.
  assign enter_press = key_prev_q[0] & ~key_sync_q[0];
  assign start_press = key_prev_q[1] & ~key_sync_q[1];
  assign digit_ok    = (sw_digit <= 4'd9);
  assign has_room    = (count_q < CW'(MAX_DIGITS));
  assign last_idx    = count_q - CW'(1);

  assign cur_digit = buf_q[idx_q];
  assign dbl       = {cur_digit, 1'b0};

  always_comb begin
    term = cur_digit;
    if (pos_odd_q) begin
      term = (dbl > 5'd9) ? 4'(dbl - 5'd9) : dbl[3:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    count_d      = count_q;
    idx_d        = idx_q;
    pos_odd_d    = pos_odd_q;
    sum_d        = sum_q;
    card_digit_d = card_digit_q;
    valid_d      = valid_q;
    pending_d    = 1'b0;
    begin_check  = 1'b0;

    case (state_q)
      IDLE: begin
        if (enter_press) begin
          if (digit_ok && has_room) begin
            buf_d[count_q[IW-1:0]] = sw_digit;
            card_digit_d           = sw_digit;
            count_d                = count_q + CW'(1);
          end
        end else if (start_press) begin
          begin_check = 1'b1;
        end
      end
      CALC: begin
        sum_d     = sum_q + {4'd0, term};
        pos_odd_d = ~pos_odd_q;
        idx_d     = idx_q - IW'(1);
        if (idx_q == '0) begin
          state_d   = DONE;
          pending_d = 1'b1;
        end
      end
      DONE: begin
        // Validity is taken one cycle after arriving from CALC, once sum_q holds the final total.
        if (pending_q) begin
          valid_d = ((sum_q % 8'd10) == 8'd0);
        end
        if (enter_press) begin
          for (int i = 0; i < MAX_DIGITS; i++) begin
            buf_d[i] = 4'd0;
          end
          valid_d = 1'b0;
          count_d = '0;
          state_d = IDLE;
          if (digit_ok) begin
            buf_d[0]     = sw_digit;
            card_digit_d = sw_digit;
            count_d      = CW'(1);
          end
        end else if (start_press) begin
          begin_check = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (begin_check) begin
      if (count_q >= CW'(2)) begin
        state_d   = CALC;
        idx_d     = last_idx[IW-1:0];
        pos_odd_d = 1'b0;
        sum_d     = '0;
      end else begin
        state_d = DONE;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      key_meta_q   <= 2'b11;
      key_sync_q   <= 2'b11;
      key_prev_q   <= 2'b11;
      count_q      <= '0;
      idx_q        <= '0;
      pos_odd_q    <= 1'b0;
      sum_q        <= '0;
      card_digit_q <= '0;
      valid_q      <= 1'b0;
      pending_q    <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
        buf_q[i] <= 4'd0;
      end
    end else begin
      state_q      <= state_d;
      key_meta_q   <= bus.KEY;
      key_sync_q   <= key_meta_q;
      key_prev_q   <= key_sync_q;
      count_q      <= count_d;
      idx_q        <= idx_d;
      pos_odd_q    <= pos_odd_d;
      sum_q        <= sum_d;
      card_digit_q <= card_digit_d;
      valid_q      <= valid_d;
      pending_q    <= pending_d;
      buf_q        <= buf_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign count_units = (count_q >= CW'(10)) ? count_q - CW'(10) : count_q;

  assign bus.HEX0 = (count_q == '0) ? 7'b1111111 : seg7(card_digit_q);
  assign bus.HEX4 = seg7(count_units[3:0]);
  assign bus.HEX5 = (count_q >= CW'(10)) ? seg7(4'd1) : 7'b1111111;
  assign bus.LEDR = {(count_q == CW'(MAX_DIGITS)), 6'd0,
                     (state_q == CALC), (state_q == DONE), valid_q};
endmodule

// File: tb/tb_luhn_card_checker.sv
// Scoreboard bench for the Luhn card checker: directed board scenarios plus random digit sequences.
module tb_luhn_card_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  luhn_card_checker_if bus ();
  luhn_card_checker #(.MAX_DIGITS(16)) dut (.CLOCK_50(clk), .reset(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int model_digits[$];
  int model_last = 0;
  bit model_done = 1'b0;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  // Reference Luhn: double every second digit counted from the right, cast out nines, sum mod 10.
  function automatic int luhn_ok(input int d[$]);
    int s = 0;
    for (int i = 0; i < d.size(); i++) begin
      int v = d[d.size() - 1 - i];
      if (i % 2 == 1) begin
        v = v * 2;
        if (v > 9) v = v - 9;
      end
      s += v;
    end
    return (d.size() >= 2 && s % 10 == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  task automatic chk_displays(input string tag);
    int c = model_digits.size();
    chk({tag, " HEX4"}, int'(bus.HEX4), int'(seg(c % 10)));
    chk({tag, " HEX5"}, int'(bus.HEX5), (c >= 10) ? int'(seg(c / 10)) : 7'h7F);
    chk({tag, " HEX0"}, int'(bus.HEX0), (c == 0) ? 7'h7F : int'(seg(model_last)));
    chk({tag, " full"}, int'(bus.LEDR[9]), (c == 16) ? 1 : 0);
  endtask

  task automatic press(input int k, input int hold);
    @(posedge clk); #1 bus.KEY[k] = 1'b0;
    repeat (hold) @(posedge clk);
    #1 bus.KEY[k] = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; bus.KEY = 2'b11; bus.SW = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_digits.delete();
    model_last = 0;
    model_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic enter_digit(input int sw, input int hold);
    bus.SW = {6'($urandom), 4'(sw)};
    if (model_done) begin
      model_digits.delete();
      model_done = 1'b0;
    end
    if (sw <= 9 && model_digits.size() < 16) begin
      model_digits.push_back(sw);
      model_last = sw;
    end
    press(0, hold);
    @(negedge clk);
    $display("enter sw=%0d hold=%0d -> count %0d", sw, hold, model_digits.size());
    chk_displays("enter");
  endtask

  // expv < 0 selects the reference model's verdict.
  task automatic start_check(input int expv, input int hold);
    int e = (expv < 0) ? luhn_ok(model_digits) : expv;
    exp_q.push_back(e);
    model_done = 1'b1;
    press(1, hold);
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      chk("result timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    $display("start count=%0d expect valid=%0d", model_digits.size(), e);
  endtask

  // Monitor: one cycle after done rises the registered validity is compared to the oldest expectation.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.LEDR[1] && !prev) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          chk("unexpected done", 1, 0);
        end else begin
          chk("validity", int'(bus.LEDR[0]), exp_q.pop_front());
          chk("busy at done", int'(bus.LEDR[2]), 0);
          chk("done held", int'(bus.LEDR[1]), 1);
        end
      end
      prev = rst ? 1'b0 : bus.LEDR[1];
    end
  end

  initial begin
    int d2[11] = '{4, 9, 9, 2, 7, 3, 9, 8, 7, 1, 6};
    int d4[16] = '{4, 9, 9, 2, 7, 3, 9, 8, 7, 1, 6, 8, 8, 8, 8, 7};
    bus.KEY = 2'b11;
    bus.SW  = '0;
    do_reset();
    chk("reset LEDR", int'(bus.LEDR), 0);
    chk("reset HEX4", int'(bus.HEX4), 7'b1000000);
    chk("reset HEX0", int'(bus.HEX0), 7'h7F);
    chk("reset HEX5", int'(bus.HEX5), 7'h7F);

    foreach (d2[i]) enter_digit(d2[i], 1 + (i % 3));
    start_check(1, 2);
    foreach (d2[i]) enter_digit((i == 10) ? 7 : d2[i], 2);
    start_check(0, 1);
    foreach (d4[i]) enter_digit(d4[i], 1);
    enter_digit(3, 1);
    start_check(0, 3);
    start_check(0, 1);

    do_reset();
    enter_digit(12, 2);
    enter_digit(5, 9);
    start_check(0, 2);

    foreach (d4[i]) enter_digit(d4[i], 1);
    @(posedge clk); #1 bus.KEY[1] = 1'b0;
    @(posedge clk); #1 bus.KEY[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("busy in calc", int'(bus.LEDR[2]), 1);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_digits.delete();
    model_done = 1'b0;
    @(negedge clk);
    chk("abort LEDR", int'(bus.LEDR), 0);
    chk_displays("abort");
    repeat (20) @(negedge clk);
    chk("abort no stale", int'(bus.LEDR), 0);

    for (int t = 0; t < 25; t++) begin
      int n = $urandom_range(0, 18);
      if (model_done && n == 0 && model_digits.size() < 2) do_reset();
      for (int j = 0; j < n; j++) begin
        int sw = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        enter_digit(sw, $urandom_range(1, 6));
      end
      if (model_done && model_digits.size() < 2) do_reset();
      start_check(-1, $urandom_range(1, 6));
      if (model_digits.size() >= 2 && $urandom_range(0, 2) == 0) start_check(-1, 1);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
